// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path:
// arbiter FSM encodings and command byte constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_e;

    // Command bytes shared by all requesters and the arbiter.
    localparam logic [7:0] CMD_LO = 8'h61;
    localparam logic [7:0] CMD_HI = 8'h6A;
    localparam logic [7:0] CMD_D0 = 8'hD0;
    localparam logic [7:0] CMD_D1 = 8'hD1;

    function automatic logic is_cmd(input logic [7:0] b);
        return ((b >= CMD_LO) && (b <= CMD_HI))
            || (b == CMD_D0) || (b == CMD_D1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker with lock override.
// Ports: req, ptr, lock, lock_id in; found, idx out.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   ptr,
    input  logic               lock,
    input  logic [REQ_W-1:0]   lock_id,
    output logic               found,
    output logic [REQ_W-1:0]   idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        if (lock) begin
            // Only the packet owner may continue.
            found = req[lock_id];
            idx   = lock_id;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (int'(ptr) + k) % NUM_REQ;
                if (!found && req[j]) begin
                    found = 1'b1;
                    idx   = REQ_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin per-packet arbiter sharing one uart_tx.
// Ports: req_valid/data/last/ready per requester,
// tx_enable/tx_data/tx_busy to uart_tx, grant_id,
// locked (packet in progress), err_timeout (sticky).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int REQ_W         = $clog2(NUM_REQ),
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_enable,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [REQ_W-1:0]     grant_id,
    output logic                 locked,
    output logic                 err_timeout
);

    localparam int TW = $clog2(START_TIMEOUT);

    arb_state_e       state;
    logic [REQ_W-1:0] ptr;
    logic [TW-1:0]    tmo_cnt;
    logic [TW-1:0]    tmo_nxt;
    logic             found;
    logic [REQ_W-1:0] win;
    logic             accept;
    logic [7:0]       win_data;
    logic             win_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .lock    (locked),
        .lock_id (grant_id),
        .found   (found),
        .idx     (win)
    );

    always_comb begin
        win_data = req_data[8*int'(win) +: 8];
        win_last = req_last[win];
    end

    // Accept is combinational so the requester sees
    // ready in the same cycle its byte is taken.
    assign accept = (state == ARB) && !tx_busy && found;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
    assign tmo_nxt = tmo_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ARB;
            tx_enable   <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            locked      <= 1'b0;
            err_timeout <= 1'b0;
            ptr         <= REQ_W'(NUM_REQ - 1);
            tmo_cnt     <= '0;
        end else begin
            tx_enable <= 1'b0;
            unique case (state)
                ARB: begin
                    if (accept) begin
                        tx_data   <= win_data;
                        grant_id  <= win;
                        locked    <= !win_last;
                        // Pointer moves per packet only.
                        if (win_last)
                            ptr <= win;
                        tx_enable <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        // Byte is dropped as consumed.
                        if (tmo_nxt == TW'(START_TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            state       <= ARB;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a
// simple uart_tx busy model and requester queues.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        err_timeout;

    logic busy_m = 1'b0;
    logic busy_f = 1'b0;
    logic model_on = 1'b1;

    int n_chk = 0;
    int n_bad = 0;

    item_t rq [4][$];
    exp_t  exq[$];

    assign tx_busy = busy_m | busy_f;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h",
                     tag, got, want);
        end
    endtask

    task automatic push(input int id,
                        input logic [7:0] d,
                        input logic l);
        item_t it;
        exp_t  e;
        it.d = d;
        it.l = l;
        rq[id].push_back(it);
        e.id = 2'(id);
        e.d  = d;
        e.l  = l;
        exq.push_back(e);
    endtask

    // Requesters: sample ready mid-cycle, update
    // the presented byte just after the next edge.
    initial begin
        logic [3:0] rdy;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            if (rdy != 4'b0)
                chk("ready_onehot", $countones(rdy), 1);
            for (int i = 0; i < 4; i++)
                if (rdy[i] && rq[i].size() > 0)
                    void'(rq[i].pop_front());
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].d;
                    req_last[i]        = rq[i][0].l;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // uart_tx model: busy for 10 cycles starting
    // one cycle after each launch.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_enable && model_on) begin
                @(posedge clk);
                #1;
                busy_m = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                busy_m = 1'b0;
            end
        end
    end

    // Launch monitor pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tx_enable) begin
                if (exq.size() == 0) begin
                    chk("tx_extra", 1, 0);
                end else begin
                    e = exq.pop_front();
                    chk("tx_data", tx_data, e.d);
                    chk("grant_id", grant_id, e.id);
                    chk("locked", locked, !e.l);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (exq.size() == 0 && !tx_busy &&
                rq[0].size() == 0 && rq[1].size() == 0 &&
                rq[2].size() == 0 && rq[3].size() == 0)
                break;
        end
        repeat (14) @(posedge clk);
        #1;
        chk(tag, exq.size(), 0);
    endtask

    initial begin
        int k;
        bit seen;
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;

        do_reset();
        @(negedge clk);
        chk("rst_tx_enable", tx_enable, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", req_ready, 0);

        // Single byte from requester 0.
        push(0, 8'h55, 1'b1);
        drain("single");

        // Round robin from a fresh pointer.
        do_reset();
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        exq.delete();
        for (int i = 0; i < 4; i++)
            exq.push_back(exp_t'{2'(i), 8'hA0 + 8'(i), 1'b1});
        rq[0].push_back(item_t'{8'hA4, 1'b1});
        exq.push_back(exp_t'{2'd0, 8'hA4, 1'b1});
        drain("rr");

        // Locked packet vs busy neighbours (ptr=0).
        rq[0].push_back(item_t'{8'hB0, 1'b1});
        rq[1].push_back(item_t'{8'hB1, 1'b1});
        rq[1].push_back(item_t'{8'hB2, 1'b1});
        rq[2].push_back(item_t'{8'h10, 1'b0});
        rq[2].push_back(item_t'{8'h11, 1'b0});
        rq[2].push_back(item_t'{8'h12, 1'b1});
        exq.push_back(exp_t'{2'd1, 8'hB1, 1'b1});
        exq.push_back(exp_t'{2'd2, 8'h10, 1'b0});
        exq.push_back(exp_t'{2'd2, 8'h11, 1'b0});
        exq.push_back(exp_t'{2'd2, 8'h12, 1'b1});
        exq.push_back(exp_t'{2'd0, 8'hB0, 1'b1});
        exq.push_back(exp_t'{2'd1, 8'hB2, 1'b1});
        drain("packet");

        // Start timeout: uart never goes busy.
        model_on = 1'b0;
        push(3, 8'h7E, 1'b1);
        for (k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (tx_enable)
                break;
        end
        chk("tmo_launch", tx_enable, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_early", err_timeout, 0);
        @(posedge clk);
        #1;
        chk("tmo_set", err_timeout, 1);
        model_on = 1'b1;
        push(0, 8'h33, 1'b1);
        drain("tmo_next");
        chk("tmo_sticky", err_timeout, 1);

        // Busy at idle start blocks accept.
        busy_f = 1'b1;
        push(0, 8'h44, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready != 4'b0)
                seen = 1'b1;
        end
        chk("busy_block", seen, 0);
        @(posedge clk);
        #1;
        busy_f = 1'b0;
        @(negedge clk);
        chk("busy_accept", req_ready, 4'b0001);
        drain("busy");
        chk("err_still", err_timeout, 1);

        // Reset in WAIT_DONE while locked.
        push(2, 8'h20, 1'b0);
        rq[2].push_back(item_t'{8'h21, 1'b1});
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_busy && locked)
                break;
        end
        chk("mid_locked", locked, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        rq[2].delete();
        exq.delete();
        @(posedge clk);
        #1;
        chk("mid_locked0", locked, 0);
        chk("mid_err0", err_timeout, 0);
        chk("mid_data0", tx_data, 8'h00);
        chk("mid_grant0", grant_id, 0);
        chk("mid_en0", tx_enable, 0);
        resetn = 1'b1;
        push(1, 8'hC1, 1'b1);
        push(3, 8'hC3, 1'b1);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d",
                 n_chk, n_bad);
        $finish;
    end

endmodule
